ccff_chain_loader: RTL and testbench

//  Sequences the configuration-chain (ccff) load for the IO/logic tiles: accepts bitstream

---
 rtl/ccff_loader_pkg.sv | 21 ++
 rtl/ccff_crc16_serial.sv | 23 ++
 rtl/ccff_chain_loader.sv | 166 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader and its CRC helpers.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial CRC-16-CCITT step, message bit fed into the MSB end.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads the ccff configuration chain from a word stream, LSB first, with an optional
// verify pass that CRC-compares the chain readback against the loaded bitstream.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output state_t            state_dbg
);

    localparam int WORDS = CHAIN_LEN / WORD_W;
    localparam int WC_W  = $clog2(WORDS + 1);
    localparam int SC_W  = $clog2(WORD_W + 1);

    if (CHAIN_LEN % WORD_W != 0) begin : g_len_check
        $error("ccff_chain_loader: CHAIN_LEN must be a multiple of WORD_W");
    end

    state_t            state;
    logic              verify_r;
    logic [WORD_W-1:0] hold_reg;
    logic              hold_full;
    logic [WORD_W-1:0] sh_reg;
    logic [SC_W-1:0]   sh_cnt;
    logic              sh_valid;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [15:0]       crc_a;
    logic [15:0]       crc_b;

    logic              start_ok;
    logic              shift;
    logic              last_bit;
    logic              accept;
    logic              reload;
    logic [WORD_W-1:0] sh_reg_nxt;
    logic [SC_W-1:0]   sh_cnt_nxt;

    // Handshake: a word moves when cfg_valid & cfg_ready are both high at a prog_clk edge;
    // cfg_ready depends only on registered state, never on cfg_valid.
    assign cfg_ready     = busy & ~hold_full & (word_cnt != WC_W'(WORDS));
    assign accept        = cfg_valid & cfg_ready;
    assign ccff_shift_en = sh_valid;
    assign ccff_head     = sh_reg[0];
    assign state_dbg     = state;

    always_comb begin
        start_ok   = start & ~abort & ((state == IDLE) | (state == DONE));
        shift      = sh_valid;
        last_bit   = shift & (bit_cnt == CNT_W'(CHAIN_LEN - 1));
        // Refill the shift register when it is empty or on its final bit, so a
        // steady stream never leaves a bubble between words.
        reload     = hold_full & (~sh_valid | (sh_cnt == SC_W'(1)));
        sh_reg_nxt = sh_reg;
        sh_cnt_nxt = sh_cnt;
        if (reload) begin
            sh_reg_nxt = hold_reg;
            sh_cnt_nxt = SC_W'(WORD_W);
        end else if (shift) begin
            sh_reg_nxt = sh_reg >> 1;
            sh_cnt_nxt = sh_cnt - SC_W'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state     <= IDLE;
            verify_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            sh_reg    <= '0;
            sh_cnt    <= '0;
            sh_valid  <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hold_full <= 1'b0;
            sh_reg    <= '0;
            sh_cnt    <= '0;
            sh_valid  <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else if (start_ok) begin
            state     <= LOAD;
            verify_r  <= verify;
            busy      <= 1'b1;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            hold_full <= 1'b0;
            sh_reg    <= '0;
            sh_cnt    <= '0;
            sh_valid  <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            done      <= 1'b0;
            hold_full <= (hold_full & ~reload) | accept;
            if (accept) begin
                hold_reg <= cfg_data;
            end
            sh_reg   <= sh_reg_nxt;
            sh_cnt   <= sh_cnt_nxt;
            sh_valid <= (sh_cnt_nxt != '0);
            if (shift) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end
            if (last_bit) begin
                word_cnt <= '0;
                if ((state == LOAD) && verify_r) begin
                    state <= VERIFY;
                end else begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    // Fold in the tail bit of this final shift before comparing.
                    if (state == VERIFY) begin
                        cfg_err <= (crc_a != crc16_step(crc_b, ccff_tail));
                    end
                end
            end else if (accept) begin
                word_cnt <= word_cnt + WC_W'(1);
            end
        end
    end

    ccff_crc16_serial u_crc_a (
        .clk    (prog_clk),
        .rst_n  (pReset_n),
        .clr    (start_ok),
        .en     (shift & (state == LOAD)),
        .bit_in (ccff_head),
        .crc    (crc_a)
    );

    ccff_crc16_serial u_crc_b (
        .clk    (prog_clk),
        .rst_n  (pReset_n),
        .clr    (start_ok),
        .en     (shift & (state == VERIFY)),
        .bit_in (ccff_tail),
        .crc    (crc_b)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a shift-register model of the fabric chain.
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    localparam int CHAIN_LEN = 64;
    localparam int WORD_W    = 8;
    localparam int WORDS     = CHAIN_LEN / WORD_W;

    logic              prog_clk = 1'b0;
    logic              pReset_n;
    logic              start;
    logic              verify;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;
    logic              cfg_err;
    state_t            state_dbg;

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int chain_shifts = 0;
    int done_cnt     = 0;
    int run_base     = 0;
    int log_base     = 0;
    int flip_req     = 0;
    int flip_ack     = 0;
    int flip_pos     = 0;

    logic [CHAIN_LEN-1:0] chain = '0;
    logic [0:0]           exp_q[$];
    int                   shift_log[$];

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .verify        (verify),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset block ----------------
    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- fabric chain model ----------------
    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        logic [CHAIN_LEN-1:0] nxt;
        nxt = chain;
        if (flip_req != flip_ack) begin
            nxt[flip_pos] = ~nxt[flip_pos];
            flip_ack <= flip_req;
        end
        if (ccff_shift_en) begin
            nxt = {nxt[CHAIN_LEN-2:0], ccff_head};
            chain_shifts <= chain_shifts + 1;
        end
        chain <= nxt;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Every shifted head bit must be the next bit of the offered stream.
    always @(negedge prog_clk) begin
        logic [0:0] e;
        if (pReset_n) begin
            if (ccff_shift_en) begin
                shift_log.push_back(cyc);
                check("shift_implies_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    timeout("head_extra_bit");
                end else begin
                    e = exp_q.pop_front();
                    check("head_bit", ccff_head, e);
                end
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // ---------------- reference helpers ----------------
    function automatic logic [15:0] crc_ref(input logic [63:0] s);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (c[15] ^ s[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [63:0] pack_words(input logic [7:0] ws[WORDS]);
        logic [63:0] s;
        for (int i = 0; i < WORDS; i++) s[8*i +: 8] = ws[i];
        return s;
    endfunction

    function automatic logic [63:0] chain_stream();
        logic [63:0] g;
        for (int k = 0; k < CHAIN_LEN; k++) g[k] = chain[CHAIN_LEN-1-k];
        return g;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic begin_run();
        run_base = chain_shifts;
        log_base = shift_log.size();
    endtask

    task automatic pulse_start(input logic v);
        @(posedge prog_clk); #1;
        start  = 1'b1;
        verify = v;
        @(posedge prog_clk); #1;
        start  = 1'b0;
        verify = 1'b0;
    endtask

    // Called at posedge+#1; returns at posedge+#1.
    task automatic send_word(input logic [7:0] w, input int gap);
        int t;
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int b = 0; b < WORD_W; b++) exp_q.push_back(w[b]);
        t = 0;
        forever begin
            @(negedge prog_clk);
            if (cfg_ready) break;
            t++;
            if (t > 300) begin
                timeout("cfg_ready_wait");
                break;
            end
        end
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;
        repeat (gap) begin
            @(posedge prog_clk); #1;
        end
    endtask

    task automatic send_stream(input logic [7:0] ws[WORDS], input int n, input bit stall);
        for (int i = 0; i < n; i++) send_word(ws[i], (stall && (i % 3 == 2)) ? 20 : 0);
    endtask

    task automatic wait_shifts(input int n, input string name);
        int t;
        t = 0;
        while (chain_shifts - run_base < n) begin
            @(negedge prog_clk);
            t++;
            if (t > 1000) begin
                timeout(name);
                break;
            end
        end
    endtask

    task automatic wait_done(input int n_exp, input logic err_exp, input string name);
        int t;
        t = 0;
        forever begin
            @(negedge prog_clk);
            if (done) break;
            t++;
            if (t > 2000) begin
                timeout(name);
                break;
            end
        end
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_state_at_done"}, state_dbg, DONE);
        check({name, "_shift_count"}, chain_shifts - run_base, n_exp);
        check({name, "_cfg_err"}, cfg_err, err_exp);
        @(negedge prog_clk);
        check({name, "_done_pulse"}, done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  w[WORDS];
        logic [63:0] s;
        logic        exp_err;
        int          span;
        int          done_before;

        pReset_n  = 1'b1;
        start     = 1'b0;
        verify    = 1'b0;
        abort     = 1'b0;
        cfg_data  = '0;
        cfg_valid = 1'b0;
        #1 pReset_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_head", ccff_head, 0);
        check("rst_shift_en", ccff_shift_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_state", state_dbg, IDLE);
        pReset_n = 1'b1;

        // Back-to-back load of 0x01..0x08.
        for (int i = 0; i < WORDS; i++) w[i] = 8'(i + 1);
        s = pack_words(w);
        begin_run();
        pulse_start(1'b0);
        check("start_busy", busy, 1);
        check("start_state", state_dbg, LOAD);
        send_stream(w, WORDS, 1'b0);
        wait_done(64, 1'b0, "b2b");
        span = shift_log[shift_log.size()-1] - shift_log[log_base] + 1;
        check("b2b_consecutive", span, 64);
        check("b2b_image", chain_stream(), s);
        check("b2b_image_literal", chain_stream(), 64'h0807060504030201);

        // Stalled stream: gaps long enough to underrun the shift register.
        w = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'hE1, 8'h5A, 8'h7E, 8'h81};
        s = pack_words(w);
        begin_run();
        pulse_start(1'b0);
        send_stream(w, WORDS, 1'b1);
        wait_done(64, 1'b0, "stall");
        span = shift_log[shift_log.size()-1] - shift_log[log_base] + 1;
        check("stall_has_gaps", (span > 64), 1);
        check("stall_shift_log", shift_log.size() - log_base, 64);
        check("stall_image", chain_stream(), s);
        check("stall_image_literal", chain_stream(), 64'h817E5AE10F963CA5);

        // Verify pass with matching re-stream.
        for (int i = 0; i < WORDS; i++) w[i] = 8'($urandom_range(0, 255));
        s = pack_words(w);
        begin_run();
        pulse_start(1'b1);
        send_stream(w, WORDS, 1'b0);
        send_stream(w, WORDS, 1'b0);
        wait_done(128, 1'b0, "verify_ok");
        check("verify_ok_image", chain_stream(), s);

        // Verify pass with one chain flop corrupted between passes.
        for (int i = 0; i < WORDS; i++) w[i] = 8'($urandom_range(0, 255));
        s = pack_words(w);
        begin_run();
        pulse_start(1'b1);
        send_stream(w, WORDS, 1'b0);
        wait_shifts(64, "verify_fail_pass1");
        check("between_passes_state", state_dbg, VERIFY);
        flip_pos = CHAIN_LEN - 1 - 10;
        flip_req = flip_req + 1;
        @(posedge prog_clk); #1;
        send_stream(w, WORDS, 1'b0);
        exp_err = (crc_ref(s) != crc_ref(s ^ (64'd1 << 10)));
        wait_done(128, exp_err, "verify_fail");
        check("verify_fail_literal", cfg_err, 1);
        check("verify_fail_image", chain_stream(), s);

        // Next start clears the error; then abort mid-load alongside a start.
        for (int i = 0; i < WORDS; i++) w[i] = 8'(8'h10 * i + 8'h09);
        begin_run();
        pulse_start(1'b0);
        check("err_cleared_by_start", cfg_err, 0);
        send_stream(w, 5, 1'b0);
        wait_shifts(37, "abort_wait");
        done_before = done_cnt;
        @(posedge prog_clk); #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge prog_clk);
        check("abort_state", state_dbg, IDLE);
        check("abort_busy", busy, 0);
        check("abort_shift_en", ccff_shift_en, 0);
        check("abort_cfg_ready", cfg_ready, 0);
        exp_q.delete();
        repeat (5) @(negedge prog_clk);
        check("abort_no_done", done_cnt, done_before);
        check("abort_stays_idle", state_dbg, IDLE);

        // A fresh start after abort runs a full load.
        for (int i = 0; i < WORDS; i++) w[i] = 8'(8'hF0 + i);
        s = pack_words(w);
        begin_run();
        pulse_start(1'b0);
        send_stream(w, WORDS, 1'b0);
        wait_done(64, 1'b0, "after_abort");
        check("after_abort_image", chain_stream(), s);

        // Asynchronous reset mid-load at bit 20.
        begin_run();
        pulse_start(1'b0);
        send_stream(w, 4, 1'b0);
        wait_shifts(20, "reset_wait");
        #2 pReset_n = 1'b0;
        #1;
        check("areset_cfg_ready", cfg_ready, 0);
        check("areset_head", ccff_head, 0);
        check("areset_shift_en", ccff_shift_en, 0);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_cfg_err", cfg_err, 0);
        check("areset_state", state_dbg, IDLE);
        repeat (2) @(negedge prog_clk);
        pReset_n = 1'b1;
        exp_q.delete();
        @(negedge prog_clk);
        check("post_reset_state", state_dbg, IDLE);
        check("post_reset_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
